// File: rtl/motion_cmd_sequencer.sv
// motion_cmd_sequencer: queued timed motion commands driving the motor mode.
// Ports: clk/rst (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_dur
// command push port; abort flushes the queue; distance feeds the obstacle
// pause; mode/cur_op/busy/paused/cmd_done/level report execution status.
module motion_cmd_sequencer #(
    parameter int DEPTH     = 4,
    parameter int DUR_W     = 29,
    parameter int DIST_W    = 20,
    parameter int STOP_DIST = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [DUR_W-1:0]         cmd_dur,
    input  logic                     abort,
    input  logic [DIST_W-1:0]        distance,
    output logic [2:0]               mode,
    output logic [2:0]               cur_op,
    output logic                     busy,
    output logic                     paused,
    output logic                     cmd_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [DIST_W-1:0] STOP_L = DIST_W'(STOP_DIST);

    localparam logic [2:0] OP_STOP  = 3'b000;
    localparam logic [2:0] OP_RIGHT = 3'b001;
    localparam logic [2:0] OP_LEFT  = 3'b010;
    localparam logic [2:0] OP_FWD   = 3'b011;
    localparam logic [2:0] OP_BACK  = 3'b100;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       op_mem  [DEPTH];
    logic [DUR_W-1:0] dur_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    logic [DUR_W-1:0] cnt, cnt_nxt;
    logic [2:0]       cur_op_q, op_nxt;
    logic             obst, obst_q;
    logic             full, empty;
    logic             push, pop, retire;

    assign full      = (count == FULL_LVL);
    assign empty     = (count == '0);
    assign cmd_ready = !full && !abort;
    assign push      = cmd_valid && cmd_ready;
    assign obst      = (distance < STOP_L);

    assign busy   = (state == RUN);
    assign paused = busy && obst_q;
    assign cur_op = cur_op_q;
    assign level  = count;

    // Command storage; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= cmd_op;
            dur_mem[wr_ptr] <= cmd_dur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            cur_op_q <= OP_STOP;
            obst_q   <= 1'b0;
            cmd_done <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            cur_op_q <= op_nxt;
            obst_q   <= obst;
            cmd_done <= retire;
        end
    end

    // Next state, pop and retire decisions. A retiring command hands over
    // to the queue head in the same cycle so modes run back-to-back.
    // A zero count marks an indefinite command: it yields to the next one.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        retire    = 1'b0;
        cnt_nxt   = cnt;
        op_nxt    = cur_op_q;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                    op_nxt    = op_mem[rd_ptr];
                    cnt_nxt   = dur_mem[rd_ptr];
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    retire = !empty;
                end else if (!obst) begin
                    if (cnt == DUR_W'(1)) begin
                        retire = 1'b1;
                    end else begin
                        cnt_nxt = cnt - DUR_W'(1);
                    end
                end
                if (retire) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        op_nxt  = op_mem[rd_ptr];
                        cnt_nxt = dur_mem[rd_ptr];
                    end else begin
                        state_nxt = IDLE;
                        op_nxt    = OP_STOP;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
            pop       = 1'b0;
            retire    = 1'b0;
            op_nxt    = OP_STOP;
            cnt_nxt   = '0;
        end
    end

    // Obstacle override: turns back off, forward halts, backward keeps going.
    always_comb begin
        mode = OP_STOP;
        if (state == RUN) begin
            case (cur_op_q)
                OP_RIGHT, OP_LEFT: mode = obst_q ? OP_BACK : cur_op_q;
                OP_FWD:            mode = obst_q ? OP_STOP : OP_FWD;
                OP_BACK:           mode = OP_BACK;
                default:           mode = OP_STOP;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Testbench for motion_cmd_sequencer: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_motion_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_dur;
    logic       abort;
    logic [19:0] distance;
    logic [2:0] mode;
    logic [2:0] cur_op;
    logic       busy;
    logic       paused;
    logic       cmd_done;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    motion_cmd_sequencer #(
        .DEPTH(4), .DUR_W(8), .DIST_W(20), .STOP_DIST(20)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dur(cmd_dur),
        .abort(abort), .distance(distance),
        .mode(mode), .cur_op(cur_op), .busy(busy),
        .paused(paused), .cmd_done(cmd_done), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2:0] op;
        logic [7:0] dur;
    } cmd_t;

    cmd_t q[$];
    bit   m_act;
    int   m_op;
    int   m_rem;
    bit   m_done;
    bit   m_obstp;

    function automatic int run_mode(input int op, input bit p);
        if (p) return (op == 1 || op == 2 || op == 4) ? 4 : 0;
        return (op >= 1 && op <= 4) ? op : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit   ob, ret, take, psh;
        int   sz;
        cmd_t c;
        if (rst) begin
            q.delete();
            m_act = 0; m_op = 0; m_rem = 0; m_done = 0; m_obstp = 0;
        end else begin
            ob  = (distance < 20);
            sz  = q.size();
            psh = cmd_valid && !abort && (sz < 4);
            if (abort) begin
                q.delete();
                m_act = 0; m_op = 0; m_rem = 0; m_done = 0;
            end else begin
                ret  = m_act && ((m_rem == 0 && sz > 0) ||
                                 (m_rem == 1 && !ob));
                take = (!m_act || ret) && (sz > 0);
                if (take) begin
                    c = q.pop_front();
                    m_act = 1; m_op = c.op; m_rem = c.dur;
                end else if (ret) begin
                    m_act = 0; m_op = 0;
                end else if (m_act && m_rem > 1 && !ob) begin
                    m_rem--;
                end
                if (psh) begin
                    c.op = cmd_op; c.dur = cmd_dur;
                    q.push_back(c);
                end
                m_done = ret;
            end
            m_obstp = ob;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mode", mode, m_act ? run_mode(m_op, m_obstp) : 0);
            chk("cur_op", cur_op, m_act ? m_op : 0);
            chk("busy", busy, m_act);
            chk("paused", paused, m_act && m_obstp);
            chk("cmd_done", cmd_done, m_done);
            chk("level", level, q.size());
            chk("cmd_ready", cmd_ready, (q.size() < 4) && !abort);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic push_now(input int op, input int dur);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_dur   = 8'(dur);
    endtask

    task automatic scen_single();
        int first = 0, n3 = 0, dk = 0;
        push_now(3, 5);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (mode == 3'd3) begin
                n3++;
                if (first == 0) first = k;
            end
            if (cmd_done) dk = k;
            tick();
        end
        chk("s1_first_fwd_cycle", first, 2);
        chk("s1_fwd_cycles", n3, 5);
        chk("s1_done_cycle", dk, 7);
        chk("s1_busy_after", busy, 0);
    endtask

    task automatic scen_chain();
        int exp_m [13] = '{0, 0, 2, 2, 2, 1, 1, 4, 4, 4, 4, 0, 0};
        int ops [3] = '{2, 1, 4};
        int durs [3] = '{3, 2, 4};
        int nd = 0;
        for (int k = 0; k <= 12; k++) begin
            if (k < 3) push_now(ops[k], durs[k]);
            else cmd_valid = 1'b0;
            @(negedge clk);
            chk("s2_mode_seq", mode, exp_m[k]);
            if (cmd_done) nd++;
            tick();
        end
        chk("s2_done_count", nd, 3);
        chk("s2_level_end", level, 0);
    endtask

    task automatic scen_pause(input int op, input int pmode);
        int nrun = 0, npm = 0, np = 0, dk = 0;
        push_now(op, 10);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            distance = (k >= 5 && k <= 8) ? 20'd15 : 20'd100;
            @(negedge clk);
            if (mode == 3'(op)) nrun++;
            if (busy && mode == 3'(pmode)) npm++;
            if (paused) np++;
            if (cmd_done) dk = k;
            tick();
        end
        distance = 20'd100;
        chk("s4_run_cycles", nrun, 10);
        chk("s4_override_cycles", npm, 4);
        chk("s4_paused_cycles", np, 4);
        chk("s4_done_cycle", dk, 16);
    endtask

    task automatic scen_fill_abort();
        int hs = 0, nd = 0;
        push_now(3, 0);
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        chk("s3_indef_busy", busy, 1);
        for (int k = 0; k < 8; k++) begin
            push_now(1, 50);
            @(negedge clk);
            if (cmd_valid && cmd_ready) hs++;
            if (cmd_done) nd++;
            tick();
        end
        @(negedge clk);
        chk("s3_handshakes", hs, 5);
        chk("s3_indef_retired", nd, 1);
        chk("s3_level_full", level, 4);
        chk("s3_ready_low", cmd_ready, 0);
        tick();
        abort = 1'b1;
        push_now(2, 7);
        #1;
        chk("s5_ready_abort", cmd_ready, 0);
        tick();
        abort = 1'b0;
        cmd_valid = 1'b0;
        chk("s5_level", level, 0);
        chk("s5_mode", mode, 0);
        chk("s5_busy", busy, 0);
        chk("s5_done", cmd_done, 0);
        tick();
        chk("s5_level_after", level, 0);
        chk("s5_done_after", cmd_done, 0);
    endtask

    task automatic scen_reset();
        int dk = 0, nz = 0;
        for (int k = 0; k < 3; k++) begin
            push_now(3, 30);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        chk("s6_level_pre", level, 2);
        chk("s6_busy_pre", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rst_mode", mode, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_level", level, 0);
        chk("s6_rst_curop", cur_op, 0);
        tick();
        rst = 1'b0;
        tick();
        push_now(0, 2);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mode != 3'd0) nz++;
            if (cmd_done) dk = k;
            tick();
        end
        chk("s6_stop_mode", nz, 0);
        chk("s6_stop_done", dk, 4);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dur   = 8'd0;
        abort     = 1'b0;
        distance  = 20'd100;
        #2;
        chk("rst_mode", mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_paused", paused, 0);
        tick();
        rst = 1'b0;
        tick();

        scen_single();
        scen_chain();
        scen_pause(3, 0);
        scen_pause(2, 4);
        scen_fill_abort();
        scen_reset();

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 45);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_dur   = ($urandom_range(0, 9) == 0) ? 8'd0
                        : 8'($urandom_range(1, 6));
            case ($urandom_range(0, 9))
                0:       distance = 20'($urandom_range(0, 19));
                1:       distance = ($urandom_range(0, 1) == 0) ? 20'd19
                                                                : 20'd20;
                default: distance = 20'($urandom_range(20, 300));
            endcase
            abort = ($urandom_range(0, 99) < 2);
            tick();
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
